regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the register file's single write port between two writeback requesters: requester 0 (load/memory unit) and requester 1 (ALU/execute). Each requester has a one-entry holding buffer with a valid/ready handshake. One buffered write per cycle is granted and driven onto registered write-port outputs. A pending-write query port lets hazard/stall logic detect writes in flight that the register file does not yet show.

## Interface
Parameters:
- DW, `DATA_WIDTH — writeback data width
- AW, `REG_ADDR_WIDTH — register address width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req_valid[1:0]  in  2  per-requester write request valid
- req_ready[1:0]  out  2  per-requester ready; combinational
- req_addr0, req_addr1  in  AW each  destination register
- req_data0, req_data1  in  DW each  write data
- rf_we  out  1  register-file write enable; registered
- rf_waddr  out  AW  register-file write address; registered
- rf_wdata  out  DW  register-file write data; registered
- chk_addr  in  AW  query address from hazard logic
- chk_pending  out  1  combinational; 1 when a non-zero write to chk_addr is buffered or on rf_* this cycle

## Operation
- Buffer i has fields full_i, addr_i, data_i.
- Accept: req_valid[i] & req_ready[i] at the edge loads the buffer and sets full_i.
- req_ready[i] = !full_i | clear_i. A buffer that is cleared this cycle can therefore accept in the same cycle, giving full throughput.
- x0 writes: a buffered entry with addr_i == 0 does not contend for the grant and never asserts rf_we. It is cleared on the next edge (clear_i = 1).
- Arbitration runs every cycle among full buffers with non-zero addresses. Exactly one grant, or none.
- The granted entry is registered into rf_we = 1, rf_waddr and rf_wdata. Its clear_i = 1.
- With no grant, rf_we = 0 on the next cycle. rf_waddr and rf_wdata hold their previous values.
- Ungranted full buffers keep their contents unchanged. req_ready stays 0 for them.
- Same destination in both buffers: both writes are issued in grant order, so the later-granted data is the final register value. No merging or dropping.
- chk_pending compares chk_addr against:
  - full buffers with non-zero addresses;
  - rf_waddr when rf_we = 1.
- chk_addr == 0 always gives chk_pending = 0.

## Timing
- Reset, asynchronous:
  - full_0 = full_1 = 0;
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0;
  - round-robin pointer favours requester 0.
- While rst_n is low, req_ready reads 2'b11 (buffers empty), but no acceptance takes effect.
- Latency: a request accepted at edge E appears on rf_* after edge E+1, if granted immediately. The register file commits it at edge E+2.
- Throughput: one rf write per cycle in total. A lone requester with valid held high sustains one write per cycle.
- Reset asserted mid-operation: buffered and in-flight writes are discarded and rf_we drops immediately. No partial write reaches the register file after reset.
- Simultaneous accept and grant on the same buffer: the old entry goes to rf_*, and the new entry occupies the buffer.

## Configuration
- WB_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit pointer names the preferred requester and flips to the non-granted requester after each contested grant.
  - When only one buffer contends, it wins and the pointer moves to the other requester.
- WB_ARB_RR_EN undefined: fixed priority, requester 0 (load) always wins.
  - Requester 1 can be starved while requester 0 streams back-to-back. This is accepted behaviour.

## Test plan
- Reset then idle: rst_n low mid-stream with both buffers full → rf_we = 0 and rf_waddr = rf_wdata = 0 immediately. After release, req_ready = 2'b11 and no write is issued.
- Single write: req0 writes x5 = 0xDEADBEEF at cycle 0 → rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF during cycle 2 only.
- Collision, RR build: both requesters send 4 writes each back-to-back to distinct registers → grants alternate 0,1,0,1,…, 8 writes in 8 consecutive cycles. Fixed-priority build: all 4 of req0's writes issue first, then req1's.
- x0 drop: req1 writes x0 = 0x1234 → rf_we never asserts, and req_ready[1] is 1 again one cycle after acceptance.
- Same-destination order: req0 writes x7 = 1 and req1 writes x7 = 2 in the same cycle (RR, pointer at 0) → x7 is written 1 then 2, final value 2.
- Pending query: chk_addr = 9 while an x9 write sits buffered and then on rf_* → chk_pending = 1 for both cycles and 0 after the commit edge. chk_addr = 0 → always 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter that shares a single register-file write port, with a pending-write query.
// The `WB_ARB_RR_EN macro selects round-robin arbitration; the default build uses fixed priority with the load unit first.
`timescale 1ns/1ps

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module regfile_wb_arbiter #(
    parameter int DW = `DATA_WIDTH,
    parameter int AW = `REG_ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [AW-1:0] req_addr0,
    input  logic [AW-1:0] req_addr1,
    input  logic [DW-1:0] req_data0,
    input  logic [DW-1:0] req_data1,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    input  logic [AW-1:0] chk_addr,
    output logic          chk_pending
);

    logic          full0, full1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] data0, data1;
    logic          cont0, cont1;
    logic          gnt0, gnt1;
    logic          clear0, clear1;
    logic          acc0, acc1;
    logic          hit0, hit1, hit_rf;

    // Only buffered writes to a non-zero register compete for the port.
    assign cont0 = full0 && (addr0 != '0);
    assign cont1 = full1 && (addr1 != '0);

`ifdef WB_ARB_RR_EN
    logic ptr;

    always_comb begin
        gnt0 = cont0 && (!cont1 || !ptr);
        gnt1 = cont1 && (!cont0 || ptr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (gnt0) begin
            ptr <= 1'b1;
        end else if (gnt1) begin
            ptr <= 1'b0;
        end
    end
`else
    always_comb begin
        gnt0 = cont0;
        gnt1 = cont1 && !cont0;
    end
`endif

    // An x0 entry is drained on the next edge without ever reaching the port.
    assign clear0 = (full0 && (addr0 == '0)) || gnt0;
    assign clear1 = (full1 && (addr1 == '0)) || gnt1;

    assign req_ready = {(!full1 || clear1), (!full0 || clear0)};
    assign acc0      = req_valid[0] && req_ready[0];
    assign acc1      = req_valid[1] && req_ready[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full0 <= 1'b0;
            addr0 <= '0;
            data0 <= '0;
        end else if (acc0) begin
            full0 <= 1'b1;
            addr0 <= req_addr0;
            data0 <= req_data0;
        end else if (clear0) begin
            full0 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full1 <= 1'b0;
            addr1 <= '0;
            data1 <= '0;
        end else if (acc1) begin
            full1 <= 1'b1;
            addr1 <= req_addr1;
            data1 <= req_data1;
        end else if (clear1) begin
            full1 <= 1'b0;
        end
    end

    // Address and data hold their last values when no write is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (gnt0) begin
            rf_we    <= 1'b1;
            rf_waddr <= addr0;
            rf_wdata <= data0;
        end else if (gnt1) begin
            rf_we    <= 1'b1;
            rf_waddr <= addr1;
            rf_wdata <= data1;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    assign hit0        = cont0 && (addr0 == chk_addr);
    assign hit1        = cont1 && (addr1 == chk_addr);
    assign hit_rf      = rf_we && (rf_waddr == chk_addr);
    assign chk_pending = (chk_addr != '0) && (hit0 || hit1 || hit_rf);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard testbench for regfile_wb_arbiter: expected writes are queued when driven and popped as rf_we fires.
// The expected collision order follows `WB_ARB_RR_EN, which matches the DUT build.
`timescale 1ns/1ps

module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          v0 = 1'b0;
    logic          v1 = 1'b0;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [AW-1:0] req_addr0 = '0;
    logic [AW-1:0] req_addr1 = '0;
    logic [DW-1:0] req_data0 = '0;
    logic [DW-1:0] req_data1 = '0;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] chk_addr = '0;
    logic          chk_pending;

    wr_t           exp_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    bit            mon_en = 1'b0;
    logic [DW-1:0] model_rf [32];

    assign req_valid = {v1, v0};

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr0   (req_addr0),
        .req_addr1   (req_addr1),
        .req_data0   (req_data0),
        .req_data1   (req_data1),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .chk_addr    (chk_addr),
        .chk_pending (chk_pending)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Holds valid until the handshake completes at a rising edge, then returns just after that edge.
    task automatic applyStimulus(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok = 1'b0;
        bit r;
        if (idx == 0) begin
            v0 = 1'b1; req_addr0 = a; req_data0 = d;
        end else begin
            v1 = 1'b1; req_addr1 = a; req_data1 = d;
        end
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            r = req_ready[idx];
            @(posedge clk);
            #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("handshake_timeout", 64'(ok), 64'(1));
    endtask

    task automatic monitorWrites();
        wr_t e;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && rf_we) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_write", 64'(rf_we), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("wr_addr", 64'(rf_waddr), 64'(e.a));
                    checkOutput("wr_data", 64'(rf_wdata), 64'(e.d));
                    model_rf[rf_waddr] = rf_wdata;
                end
            end
        end
    endtask

    task automatic waitDrain();
        for (int n = 0; n < 50; n++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        @(negedge clk);
        checkOutput("queue_drain", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic doReset();
        v0 = 1'b0;
        v1 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic testCollision();
        wr_t w;
        for (int i = 0; i < 4; i++) begin
`ifdef WB_ARB_RR_EN
            w.a = AW'(1 + i);  w.d = 32'hA000 + i; exp_q.push_back(w);
            w.a = AW'(10 + i); w.d = 32'hB000 + i; exp_q.push_back(w);
`else
            w.a = AW'(1 + i);  w.d = 32'hA000 + i; exp_q.push_back(w);
`endif
        end
`ifndef WB_ARB_RR_EN
        for (int i = 0; i < 4; i++) begin
            w.a = AW'(10 + i); w.d = 32'hB000 + i; exp_q.push_back(w);
        end
`endif
        fork
            begin
                for (int i = 0; i < 4; i++) applyStimulus(0, AW'(1 + i), 32'hA000 + i);
                v0 = 1'b0;
            end
            begin
                for (int i = 0; i < 4; i++) applyStimulus(1, AW'(10 + i), 32'hB000 + i);
                v1 = 1'b0;
            end
            begin
                bit found = 1'b0;
                int run = 1;
                for (int n = 0; n < 20; n++) begin
                    @(negedge clk);
                    if (rf_we) begin
                        found = 1'b1;
                        break;
                    end
                end
                checkOutput("burst_start", 64'(found), 64'(1));
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (!rf_we) break;
                    run++;
                end
                checkOutput("burst_len", 64'(run), 64'(8));
            end
        join
        waitDrain();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        wr_t w;
        fork
            monitorWrites();
        join_none

        // Reset state, observed while reset is held.
        #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_we", 64'(rf_we), 64'(0));
        checkOutput("rst_waddr", 64'(rf_waddr), 64'(0));
        checkOutput("rst_wdata", 64'(rf_wdata), 64'(0));
        checkOutput("rst_ready", 64'(req_ready), 64'(3));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // A single write appears on the port only during the second cycle after it is driven.
        w.a = 5; w.d = 32'hDEADBEEF; exp_q.push_back(w);
        v0 = 1'b1; req_addr0 = 5; req_data0 = 32'hDEADBEEF;
        @(posedge clk);
        #1 v0 = 1'b0;
        @(negedge clk);
        checkOutput("single_c1_we", 64'(rf_we), 64'(0));
        @(negedge clk);
        checkOutput("single_c2_we", 64'(rf_we), 64'(1));
        @(negedge clk);
        checkOutput("single_c3_we", 64'(rf_we), 64'(0));
        waitDrain();

        doReset();
        testCollision();

        // A write to x0 is dropped, and its buffer accepts again on the next cycle.
        doReset();
        chk_addr = 0;
        v1 = 1'b1; req_addr1 = 0; req_data1 = 32'h1234;
        @(posedge clk);
        #1 v1 = 1'b0;
        @(negedge clk);
        checkOutput("x0_ready1_c1", 64'(req_ready[1]), 64'(1));
        checkOutput("x0_we_c1", 64'(rf_we), 64'(0));
        checkOutput("x0_pending", 64'(chk_pending), 64'(0));
        @(negedge clk);
        checkOutput("x0_we_c2", 64'(rf_we), 64'(0));
        checkOutput("x0_ready_c2", 64'(req_ready), 64'(3));
        @(negedge clk);
        checkOutput("x0_we_c3", 64'(rf_we), 64'(0));

        // Both requesters target x7 in the same cycle; requester 0's write goes first.
        doReset();
        w.a = 7; w.d = 1; exp_q.push_back(w);
        w.a = 7; w.d = 2; exp_q.push_back(w);
        fork
            begin applyStimulus(0, 7, 1); v0 = 1'b0; end
            begin applyStimulus(1, 7, 2); v1 = 1'b0; end
        join
        waitDrain();
        checkOutput("x7_final", 64'(model_rf[7]), 64'(2));

        // Pending query covers the buffered cycle and the on-port cycle.
        doReset();
        chk_addr = 9;
        w.a = 9; w.d = 32'h99; exp_q.push_back(w);
        v0 = 1'b1; req_addr0 = 9; req_data0 = 32'h99;
        @(negedge clk);
        checkOutput("pend_c0", 64'(chk_pending), 64'(0));
        @(posedge clk);
        #1 v0 = 1'b0;
        @(negedge clk);
        checkOutput("pend_buffered", 64'(chk_pending), 64'(1));
        @(negedge clk);
        checkOutput("pend_on_rf", 64'(chk_pending), 64'(1));
        chk_addr = 0;
        #1;
        checkOutput("pend_x0", 64'(chk_pending), 64'(0));
        chk_addr = 9;
        @(negedge clk);
        checkOutput("pend_after_commit", 64'(chk_pending), 64'(0));
        waitDrain();

        // Reset asserted mid-stream with both buffers full and a write on the port.
        mon_en = 1'b0;
        v0 = 1'b1; req_addr0 = 3; req_data0 = 32'h33;
        v1 = 1'b1; req_addr1 = 4; req_data1 = 32'h44;
        @(negedge clk);
        @(negedge clk);
        checkOutput("midrst_pre_we", 64'(rf_we), 64'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_we", 64'(rf_we), 64'(0));
        checkOutput("midrst_waddr", 64'(rf_waddr), 64'(0));
        checkOutput("midrst_wdata", 64'(rf_wdata), 64'(0));
        checkOutput("midrst_ready", 64'(req_ready), 64'(3));
        @(posedge clk);
        #1;
        v0 = 1'b0;
        v1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("postrst_we", 64'(rf_we), 64'(0));
            checkOutput("postrst_ready", 64'(req_ready), 64'(3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
